fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port run, input, 1 bit: level; 1 = free-running execution.
REQ-004 The block SHALL have port step, input, 1 bit: level; each rising edge executes exactly one instruction while halted.
REQ-005 The block SHALL have port Prog_data, input, 8 bits: program ROM byte at address PC, combinational.
REQ-006 The block SHALL have ports IncPC, LoadPC and LoadFlags, inputs, 1 bit each: control strobes from the decode block.
REQ-007 The block SHALL have ports C_in and Z_in, inputs, 1 bit each: ALU carry and zero results.
REQ-008 The block SHALL have port PC, output, 12 bits: program ROM address.
REQ-009 The block SHALL have port Phase, output, 1 bit: 0 = fetch cycle, 1 = execute cycle; drives the decode block.
REQ-010 The block SHALL have ports Instr and Oprnd, outputs, 4 bits each: opcode and operand nibbles of the latched instruction.
REQ-011 The block SHALL have ports C_flag and Z_flag, outputs, 1 bit each: registered flags; drive the decode block.
REQ-012 The block SHALL have port Halted, output, 1 bit: 1 while in state HALT.
REQ-013 The block SHALL have port Instr_count, output, 16 bits: number of completed instructions.

Function
REQ-014 The block SHALL implement a 3-state machine: HALT, FETCH, EXEC.
REQ-015 Phase SHALL be 1 only in EXEC and 0 in HALT and FETCH.
REQ-016 Halted SHALL be 1 only in HALT.
REQ-017 HALT -> FETCH SHALL occur when run=1, or on a step rising edge, which also sets an internal one_shot flag.
REQ-018 In HALT, PC, the fetch register, the flags and Instr_count SHALL hold.
REQ-019 In HALT, IncPC, LoadPC and LoadFlags SHALL be ignored.
REQ-020 FETCH -> EXEC SHALL occur unconditionally after 1 cycle.
REQ-021 At the end of FETCH, the fetch register SHALL load Prog_data.
REQ-022 Instr SHALL equal fetch register bits [7:4] and Oprnd SHALL equal bits [3:0].
REQ-023 At the end of EXEC, the next state SHALL be FETCH if run=1 and one_shot=0; otherwise the next state SHALL be HALT and one_shot SHALL be cleared.
REQ-024 Deasserting run mid-instruction SHALL complete the current EXEC before entering HALT; the block SHALL never abandon a fetched instruction.
REQ-025 PC update in FETCH or EXEC: if LoadPC=1, PC SHALL load {Oprnd, Prog_data}; else if IncPC=1, PC SHALL become PC+1 modulo 4096 (12'hFFF -> 12'h000); else PC SHALL hold.
REQ-026 LoadPC SHALL take priority when LoadPC and IncPC are both 1.
REQ-027 In FETCH, the jump target SHALL use the Oprnd value from before the fetch register update.
REQ-028 Flag update: in EXEC with LoadFlags=1, C_flag SHALL load C_in and Z_flag SHALL load Z_in.
REQ-029 LoadFlags in FETCH SHALL be ignored.
REQ-030 Instr_count SHALL increment by 1 at the end of each EXEC and saturate at 16'hFFFF.
REQ-031 Step edge detection SHALL use a registered copy of step; a rising edge seen outside HALT SHALL be discarded, not queued.
REQ-032 When run=1 and a step edge occur together in HALT, the block SHALL take the step (one_shot=1) path.
REQ-033 Instruction latency SHALL be 2 cycles (FETCH + EXEC) from leaving HALT to Instr_count update.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL set state=HALT, PC=0, fetch register=0, C_flag=0, Z_flag=0, one_shot=0, Instr_count=0 and step history=0, overriding all other inputs.
REQ-035 Reset SHALL take effect in any state, including mid-EXEC; the interrupted instruction SHALL not update the flags or Instr_count.
REQ-036 After reset release, the block SHALL remain in HALT until run or a step edge.

Verification
REQ-037 Scenario: reset, run=1, Prog_data=8'h4A, IncPC=1 each cycle -> Phase sequence 0,1,0,1; Instr=4, Oprnd=A after first FETCH; PC=2 and Instr_count=1 after first EXEC.
REQ-038 Scenario: in EXEC with Oprnd=4'h3, Prog_data=8'hC5, LoadPC=1 and IncPC=1 -> PC=12'h3C5 next cycle.
REQ-039 Scenario: PC=12'hFFF, IncPC=1 in FETCH -> PC=12'h000, no other side effect.
REQ-040 Scenario: halted, run=0, one step pulse held 5 cycles -> exactly one FETCH+EXEC, Instr_count +1, Halted=1 again after 2 cycles.
REQ-041 Scenario: run dropped during FETCH -> EXEC still executes, flags update if LoadFlags=1 (C_in=1, Z_in=0 -> C_flag=1, Z_flag=0), then HALT.
REQ-042 Scenario: reset asserted in EXEC with LoadFlags=1 -> next cycle Halted=1, PC=0, flags=0, Instr_count unchanged from 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-phase fetch/execute sequencer for a small nibble CPU.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run, step         free-run level, single-step (rising edge, halted only)
//   Prog_data[7:0]    ROM byte at address PC
//   IncPC, LoadPC     PC control strobes from decode
//   LoadFlags         flag load strobe from decode (used in EXEC only)
//   C_in, Z_in        ALU carry / zero
//   PC[11:0]          ROM address
//   Phase             0 = fetch, 1 = execute
//   Instr, Oprnd      opcode / operand nibbles of the latched instruction
//   C_flag, Z_flag    registered flags
//   Halted            1 while halted
//   Instr_count[15:0] completed instructions, saturating
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [7:0]  Prog_data,
  input  logic        IncPC,
  input  logic        LoadPC,
  input  logic        LoadFlags,
  input  logic        C_in,
  input  logic        Z_in,
  output logic [11:0] PC,
  output logic        Phase,
  output logic [3:0]  Instr,
  output logic [3:0]  Oprnd,
  output logic        C_flag,
  output logic        Z_flag,
  output logic        Halted,
  output logic [15:0] Instr_count
);

  typedef enum logic [1:0] {HALT = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;

  state_t      state_q;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  fetch_q;
  logic        c_q, z_q;
  logic        one_shot_q;
  logic        step_q;
  logic [15:0] cnt_q, cnt_d;
  logic        step_rise;

  assign step_rise = step & ~step_q;

  // Jump target uses the operand currently latched, i.e. before a FETCH
  // overwrites the fetch register on the same edge.
  always_comb begin
    pc_d = pc_q;
    if (LoadPC)     pc_d = {fetch_q[3:0], Prog_data};
    else if (IncPC) pc_d = pc_q + 12'd1;
  end

  always_comb begin
    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HALT;
      pc_q       <= '0;
      fetch_q    <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      one_shot_q <= 1'b0;
      step_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // Step history always tracks, so an edge outside HALT is consumed.
      step_q <= step;
      unique case (state_q)
        HALT: begin
          // Step wins over run so a simultaneous edge yields one instruction.
          if (step_rise) begin
            state_q    <= FETCH;
            one_shot_q <= 1'b1;
          end else if (run) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          pc_q    <= pc_d;
          fetch_q <= Prog_data;
          state_q <= EXEC;
        end
        EXEC: begin
          pc_q  <= pc_d;
          cnt_q <= cnt_d;
          if (LoadFlags) begin
            c_q <= C_in;
            z_q <= Z_in;
          end
          if (run && !one_shot_q) begin
            state_q <= FETCH;
          end else begin
            state_q    <= HALT;
            one_shot_q <= 1'b0;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign PC          = pc_q;
  assign Phase       = (state_q == EXEC);
  assign Halted      = (state_q == HALT);
  assign Instr       = fetch_q[7:4];
  assign Oprnd       = fetch_q[3:0];
  assign C_flag      = c_q;
  assign Z_flag      = z_q;
  assign Instr_count = cnt_q;

endmodule
